// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between uart_rx, the receive FIFO and the CPU read mux.
// The master side drives bytes and CPU strobes; the FIFO is the slave.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_read;
  logic          pop;
  logic          clr_ovf;
  logic [7:0]    dout;
  logic [7:0]    status;
  logic [AW:0]   level;
  logic          rx_hold;

  modport master (
    output rx_valid, rx_data, pop, clr_ovf,
    input  rx_read, dout, status, level, rx_hold
  );

  modport slave (
    input  rx_valid, rx_data, pop, clr_ovf,
    output rx_read, dout, status, level, rx_hold
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and the CPU: power-of-two ring buffer with
// wrap-bit pointers, sticky overflow flag and an RTS hold request.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int RTS_LEVEL = 12
) (
  input  logic           cpu_clk,
  input  logic           rstn,
  uart_rx_fifo_if.slave  bus
);
  localparam logic [AW:0] RTS_LVL = RTS_LEVEL[AW:0];

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        ovf_reg;

  logic        empty;
  logic        full;
  logic        push_en;
  logic        pop_en;
  logic [AW:0] level;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign push_en = rstn && bus.rx_valid && !full;
  assign pop_en  = bus.pop && !empty;

  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // A byte offered while full sets the flag even if the CPU clears it now
      if (bus.rx_valid && full) ovf_reg <= 1'b1;
      else if (bus.clr_ovf)     ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (push_en) mem[wr_ptr_reg[AW-1:0]] <= bus.rx_data;
  end

  // Asynchronous head read: the CPU samples the byte in the same cycle it pops it
  assign bus.dout    = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];
  assign bus.rx_read = push_en;
  assign bus.level   = level;
  assign bus.rx_hold = (level >= RTS_LVL);

  assign bus.status[0] = !empty;
  assign bus.status[1] = full;
  assign bus.status[2] = ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_status_level
      if (gi <= AW) begin : g_bit
        assign bus.status[3+gi] = level[gi];
      end else begin : g_pad
        assign bus.status[3+gi] = 1'b0;
      end
    end
  endgenerate
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for single-cycle behaviour
// plus hand-written sequences for fill/overflow, wrap, clear and reset.
module tb_uart_rx_fifo;
  localparam int AW = 4;

  logic cpu_clk = 1'b0;
  logic rstn    = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  uart_rx_fifo_if #(.AW(AW)) bus ();

  uart_rx_fifo #(.DEPTH(16), .AW(AW), .RTS_LEVEL(12)) dut (
    .cpu_clk (cpu_clk),
    .rstn    (rstn),
    .bus     (bus.slave)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       pop;
    logic       clr_ovf;
    logic       exp_rx_read;
    logic [7:0] exp_dout;
    logic [7:0] exp_status;
    logic [4:0] exp_level;
    logic       exp_rx_hold;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic v, input logic [7:0] d, input logic p, input logic c);
    @(negedge cpu_clk);
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.pop      = p;
    bus.clr_ovf  = c;
    #1;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.pop      = 1'b0;
    bus.clr_ovf  = 1'b0;

    //            v   data   pop  clr  rd   dout   stat   lvl  hold
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'd0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 8'h09, 5'd1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 8'h09, 5'd1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0};
    vecs[7]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 5'd0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 8'h09, 5'd1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55, 8'h09, 5'd1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0};

    // Reset for two edges
    repeat (2) @(negedge cpu_clk);
    #1;
    chk("reset_rx_read", {31'd0, bus.rx_read}, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rx_valid, vecs[i].rx_data, vecs[i].pop, vecs[i].clr_ovf);
      chk("vec_rx_read", {31'd0, bus.rx_read}, {31'd0, vecs[i].exp_rx_read});
      chk("vec_dout",    {24'd0, bus.dout},    {24'd0, vecs[i].exp_dout});
      chk("vec_status",  {24'd0, bus.status},  {24'd0, vecs[i].exp_status});
      chk("vec_level",   {27'd0, bus.level},   {27'd0, vecs[i].exp_level});
      chk("vec_rx_hold", {31'd0, bus.rx_hold}, {31'd0, vecs[i].exp_rx_hold});
      $display("vec %0d: v=%0b d=%02h pop=%0b -> rd=%0b dout=%02h status=%02h level=%0d",
               i, vecs[i].rx_valid, vecs[i].rx_data, vecs[i].pop,
               bus.rx_read, bus.dout, bus.status, bus.level);
    end

    // Fill 16 bytes; rx_hold follows level combinationally
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_rx_read", {31'd0, bus.rx_read}, 32'd1);
      chk("fill_rx_hold", {31'd0, bus.rx_hold}, (i >= 12) ? 32'd1 : 32'd0);
      $display("fill push %02h level=%0d hold=%0b", i, bus.level, bus.rx_hold);
    end
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("full_status",  {24'd0, bus.status}, 32'h83);
    chk("full_level",   {27'd0, bus.level},  32'd16);
    chk("full_rx_read", {31'd0, bus.rx_read}, 32'd0);
    chk("full_rx_hold", {31'd0, bus.rx_hold}, 32'd1);
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("ovf_status",   {24'd0, bus.status}, 32'h87);
    chk("ovf_pop_dout", {24'd0, bus.dout},   32'h00);
    chk("ovf_rx_read",  {31'd0, bus.rx_read}, 32'd0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("late_rx_read", {31'd0, bus.rx_read}, 32'd1);
    chk("late_level",   {27'd0, bus.level},  32'd15);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("refill_level", {27'd0, bus.level},  32'd16);
    chk("refill_stat",  {24'd0, bus.status}, 32'h87);
    for (int j = 0; j < 16; j++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_dout", {24'd0, bus.dout}, (j < 15) ? 32'(j + 1) : 32'hAA);
      $display("drain pop %0d dout=%02h", j, bus.dout);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drained_status", {24'd0, bus.status}, 32'h04);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_status", {24'd0, bus.status}, 32'h00);

    // Preload three, then push+pop every cycle across pointer wrap
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 8'(8'h13 + k), 1'b1, 1'b0);
      chk("wrap_dout",    {24'd0, bus.dout},   32'(8'h10 + k));
      chk("wrap_level",   {27'd0, bus.level},  32'd3);
      chk("wrap_rx_read", {31'd0, bus.rx_read}, 32'd1);
      $display("wrap %0d dout=%02h level=%0d", k, bus.dout, bus.level);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("wrap_status", {24'd0, bus.status}, 32'h19);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_tail", {24'd0, bus.dout}, 32'(8'h38 + k));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("wrap_empty", {27'd0, bus.level}, 32'd0);

    // Set and clear coinciding: set wins
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("coinc_rx_read", {31'd0, bus.rx_read}, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("coinc_status", {24'd0, bus.status}, 32'h87);
    for (int i = 0; i < 11; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("five_status", {24'd0, bus.status}, 32'h2D);
    chk("five_dout",   {24'd0, bus.dout},   32'hCB);

    // Reset with 5 bytes buffered and ovf set
    @(negedge cpu_clk);
    rstn = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h77;
    #1;
    chk("rst_rx_read", {31'd0, bus.rx_read}, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rstn = 1'b1;
    #1;
    chk("rst_level",  {27'd0, bus.level},  32'd0);
    chk("rst_dout",   {24'd0, bus.dout},   32'd0);
    chk("rst_status", {24'd0, bus.status}, 32'd0);
    chk("rst_hold",   {31'd0, bus.rx_hold}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
